// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets, CTRL fields, modes and FSM states for timer_dev
package timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } timerState_t;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped 32-bit down-counting timer with one-shot/auto-reload modes
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int CTRL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Addr,
    input  logic             WE,
    input  logic [CNT_W-1:0] Din,
    output logic [CNT_W-1:0] Dout,
    output logic             IRQ
);

    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  preset;
    logic [CNT_W-1:0]  count;
    logic              irqFlag;
    timerState_t       state, nextState;

    logic       enable;
    logic [1:0] mode;
    logic       ctrlWr, presetWr;
    logic       loadCount, decCount, setIrq, clrIrq, endOneShot;
    logic       unusedAddr;

    assign enable     = ctrl[CTRL_EN];
    assign mode       = ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign ctrlWr     = WE && (Addr[3:2] == OFF_CTRL);
    assign presetWr   = WE && (Addr[3:2] == OFF_PRESET);
    assign unusedAddr = ^{Addr[31:4], Addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The FSM always acts on the pre-edge CTRL value; a same-edge software write is seen next edge.
    always_comb begin
        nextState  = state;
        loadCount  = 1'b0;
        decCount   = 1'b0;
        setIrq     = 1'b0;
        clrIrq     = 1'b0;
        endOneShot = 1'b0;
        if (!enable) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: nextState = LOAD;
                LOAD: begin
                    loadCount = 1'b1;
                    nextState = CNT;
                end
                CNT: begin
                    if (count == '0) begin
                        setIrq    = 1'b1;
                        nextState = INT;
                    end else begin
                        decCount = 1'b1;
                    end
                end
                INT: begin
                    if (mode == MODE_RELOAD) begin
                        clrIrq    = 1'b1;
                        nextState = LOAD;
                    end else begin
                        endOneShot = 1'b1;
                        nextState  = IDLE;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // Software writes take priority over hardware updates of CTRL and irqFlag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            irqFlag <= 1'b0;
        end else begin
            if (ctrlWr) begin
                ctrl <= Din[CTRL_W-1:0];
            end else if (endOneShot) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (presetWr) begin
                preset <= Din;
            end

            if (loadCount) begin
                count <= preset;
            end else if (decCount) begin
                count <= count - 1'b1;
            end

            if (ctrlWr || clrIrq) begin
                irqFlag <= 1'b0;
            end else if (setIrq) begin
                irqFlag <= 1'b1;
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            OFF_CTRL:   Dout = {{(CNT_W-CTRL_W){1'b0}}, ctrl};
            OFF_PRESET: Dout = preset;
            OFF_COUNT:  Dout = count;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = irqFlag & ctrl[CTRL_IM];

endmodule
